// File: rtl/dvs_event_assembler.sv
// rtl/dvs_event_assembler.sv - pairs AER Y/X words into {y,x,pol} events and queues them in a FIFO.
// Define DVS_EVT_STATS_EN to build the orphan/overflow statistics counters.
module dvs_event_assembler #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     rx_valid,
  input  logic [9:0]               aer_rx,
  input  logic                     xsel_rx,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [19:0]              evt_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              orphan_cnt,
  output logic [15:0]              overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {NO_Y, HAVE_Y} state_t;

  state_t        state, state_nxt;
  logic          y_load, push_req;
  logic [9:0]    y_hold;

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc, head_idx;
  logic [LW-1:0] level, level_after_pop;
  logic          full, pop, push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NO_Y;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr)                          state_nxt = NO_Y;
    else if (rx_valid && !xsel_rx)    state_nxt = HAVE_Y;
  end

  always_comb begin
    y_load   = !clr && rx_valid && !xsel_rx;
    push_req = !clr && rx_valid && xsel_rx && (state == HAVE_Y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      y_hold <= '0;
    else if (clr)    y_hold <= '0;
    else if (y_load) y_hold <= aer_rx;
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign full            = (level == LW'(DEPTH));
  assign pop             = evt_valid && evt_ready;
  assign push            = push_req && (!full || pop);
  assign rd_ptr_inc      = rd_ptr + AW'(1);
  assign head_idx        = pop ? rd_ptr_inc : rd_ptr;
  assign level_after_pop = level - LW'(pop);
  assign fifo_level      = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {y_hold, aer_rx};
  end

  // Output stage shows entries that were stored before this edge, so a push
  // into an empty FIFO becomes visible one cycle after it lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      evt_valid <= 1'b0;
      evt_data  <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      evt_valid <= 1'b0;
      evt_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      level     <= level_after_pop + LW'(push);
      evt_valid <= (level_after_pop != '0);
      evt_data  <= (level_after_pop != '0) ? mem[head_idx] : '0;
    end
  end

`ifdef DVS_EVT_STATS_EN
  logic orphan, drop;

  assign orphan = !clr && rx_valid && xsel_rx && (state == NO_Y);
  assign drop   = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orphan_cnt   <= '0;
      overflow_cnt <= '0;
    end else begin
      if (orphan && orphan_cnt != 16'hFFFF)   orphan_cnt   <= orphan_cnt + 16'd1;
      if (drop && overflow_cnt != 16'hFFFF)   overflow_cnt <= overflow_cnt + 16'd1;
    end
  end
`else
  assign orphan_cnt   = '0;
  assign overflow_cnt = '0;
`endif

endmodule

// File: tb/tb_dvs_event_assembler.sv
// tb/tb_dvs_event_assembler.sv - randomized and directed bench against a queue-based event model.
module tb_dvs_event_assembler;

  localparam int DEPTH = 8;
`ifdef DVS_EVT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        rx_valid = 1'b0;
  logic [9:0]  aer_rx = '0;
  logic        xsel_rx = 1'b0;
  logic        evt_ready = 1'b0;
  logic        evt_valid;
  logic [19:0] evt_data;
  logic [3:0]  fifo_level;
  logic [15:0] orphan_cnt;
  logic [15:0] overflow_cnt;

  dvs_event_assembler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rx_valid(rx_valid), .aer_rx(aer_rx),
    .xsel_rx(xsel_rx), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .fifo_level(fifo_level), .orphan_cnt(orphan_cnt), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] d;
    int          t;
  } ent_t;

  ent_t       q[$];
  bit         have_y;
  logic [9:0] y_m;
  int         orphan_m, ovf_m, cyc;
  int         n_total, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // An event is visible once it has been stored for at least one full edge.
  function automatic bit model_valid();
    return (q.size() > 0) && (q[0].t < cyc);
  endfunction

  task automatic check_outputs(input string tag);
    bit v;
    v = model_valid();
    check({tag, "_valid"}, 32'(evt_valid), 32'(v));
    if (v) check({tag, "_data"}, 32'(evt_data), 32'(q[0].d));
    check({tag, "_level"}, 32'(fifo_level), 32'(q.size()));
    check({tag, "_orphan"}, 32'(orphan_cnt), STATS ? 32'(orphan_m) : 32'd0);
    check({tag, "_ovf"}, 32'(overflow_cnt), STATS ? 32'(ovf_m) : 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    have_y   = 1'b0;
    y_m      = '0;
    orphan_m = 0;
    ovf_m    = 0;
  endtask

  task automatic step(input string tag, input bit c, input bit rv, input logic [9:0] w,
                      input bit xs, input bit rd);
    bit   v;
    ent_t e;
    clr = c; rx_valid = rv; aer_rx = w; xsel_rx = xs; evt_ready = rd;
    v = model_valid();
    cyc++;
    if (c) begin
      q.delete();
      have_y = 1'b0;
      y_m    = '0;
    end else begin
      if (v && rd) e = q.pop_front();
      if (rv && !xs) begin
        have_y = 1'b1;
        y_m    = w;
      end else if (rv && xs) begin
        if (!have_y) begin
          if (orphan_m < 65535) orphan_m++;
        end else if (q.size() < DEPTH) begin
          e.d = {y_m, w[9:1], w[0]};
          e.t = cyc;
          q.push_back(e);
        end else if (ovf_m < 65535) ovf_m++;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input bit rd, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 10'd0, 1'b0, rd);
  endtask

  int ovf_before;

  initial begin
    n_total = 0; n_pass = 0; cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset_data", 32'(evt_data), 32'd0);
    rst_n = 1'b1;

    // orphan X after reset, then a properly paired event
    step("r033_orph", 1'b0, 1'b1, 10'h010, 1'b1, 1'b1);
    check("r033_orph_cnt", 32'(orphan_cnt), STATS ? 32'd1 : 32'd0);
    step("r033_y", 1'b0, 1'b1, 10'h001, 1'b0, 1'b0);
    step("r033_x", 1'b0, 1'b1, 10'h010, 1'b1, 1'b0);
    step("r033_wait", 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    check("r033_evt", 32'(evt_data), 32'({10'h001, 9'h008, 1'b0}));
    idle("r033_drain", 1'b1, 2);

    // two-cycle latency from the X strobe
    step("r032_y", 1'b0, 1'b1, 10'h05A, 1'b0, 1'b1);
    step("r032_x", 1'b0, 1'b1, 10'h0C7, 1'b1, 1'b1);
    check("r032_lat1", 32'(evt_valid), 32'd0);
    step("r032_wait", 1'b0, 1'b0, 10'h000, 1'b0, 1'b1);
    check("r032_valid", 32'(evt_valid), 32'd1);
    check("r032_evt", 32'(evt_data), 32'({10'h05A, 9'h063, 1'b1}));
    idle("r032_drain", 1'b1, 2);

    // overflow: 10 X words into an 8-deep FIFO with the consumer stalled
    ovf_before = ovf_m;
    step("r034_y", 1'b0, 1'b1, 10'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("r034_x", 1'b0, 1'b1, 10'($urandom), 1'b1, 1'b0);
    check("r034_level", 32'(fifo_level), 32'd8);
    check("r034_ovf", 32'(overflow_cnt), STATS ? 32'(ovf_before + 2) : 32'd0);
    step("r035_x", 1'b0, 1'b1, 10'($urandom), 1'b1, 1'b1);
    check("r035_level", 32'(fifo_level), 32'd8);
    check("r035_ovf", 32'(overflow_cnt), STATS ? 32'(ovf_before + 2) : 32'd0);
    idle("r035_drain", 1'b1, 12);

    // clr concurrent with an X strobe
    step("r036_y", 1'b0, 1'b1, 10'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("r036_x", 1'b0, 1'b1, 10'($urandom), 1'b1, 1'b0);
    step("r036_clr", 1'b1, 1'b1, 10'($urandom), 1'b1, 1'b0);
    check("r036_level", 32'(fifo_level), 32'd0);
    check("r036_valid", 32'(evt_valid), 32'd0);
    step("r036_orph", 1'b0, 1'b1, 10'($urandom), 1'b1, 1'b1);

    // randomized traffic, stalled-consumer bias in the first half
    for (int i = 0; i < 1500; i++) begin
      step("rand", ($urandom_range(0, 63) == 0), 1'($urandom), 10'($urandom),
           ($urandom_range(0, 3) != 0),
           (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0));
    end
    idle("rand_drain", 1'b1, 12);

    // asynchronous reset with 5 events buffered
    step("r037_y", 1'b0, 1'b1, 10'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("r037_x", 1'b0, 1'b1, 10'($urandom), 1'b1, 1'b0);
    idle("r037_fill", 1'b0, 1);
    check("r037_level_pre", 32'(fifo_level), 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("r037_async");
    check("r037_data", 32'(evt_data), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs("r028_post");
    step("r028_orph", 1'b0, 1'b1, 10'($urandom), 1'b1, 1'b1);
    idle("r028_idle", 1'b1, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dvs_event_assembler.md
DVS_EVENT_ASSEMBLER -- requirements
Module: dvs_event_assembler

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entry count (power of two, >= 2).
REQ-002 The block SHALL have port clk, input, 1, system clock.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port clr, input, 1, synchronous flush of the FIFO and the held Y address.
REQ-005 The block SHALL have port rx_valid, input, 1, one-cycle strobe marking a newly received AER word.
REQ-006 The block SHALL have port aer_rx, input, 10, received AER word.
REQ-007 The block SHALL have port xsel_rx, input, 1, word type (0 = Y address, 1 = X address).
REQ-008 The block SHALL have port evt_valid, output, 1, FIFO head holds a valid event.
REQ-009 The block SHALL have port evt_ready, input, 1, consumer accepts head event.
REQ-010 The block SHALL have port evt_data, output, 20, head event {y[9:0], x[8:0], pol}.
REQ-011 The block SHALL have port fifo_level, output, $clog2(DEPTH)+1, current occupancy.
REQ-012 The block SHALL have port orphan_cnt, output, 16, X words dropped for lack of a held Y.
REQ-013 The block SHALL have port overflow_cnt, output, 16, events dropped because the FIFO was full.

Function
REQ-014 Y word (rx_valid=1, xsel_rx=0): y_hold SHALL load aer_rx[9:0] at the next edge; FSM enters HAVE_Y.
REQ-015 FSM SHALL have two states: NO_Y (reset state, no Y held) and HAVE_Y; only a Y word or clr/reset changes state.
REQ-016 X word in HAVE_Y: event {y_hold, aer_rx[9:1], aer_rx[0]} SHALL be pushed at the next edge; state stays HAVE_Y.
REQ-017 X word in NO_Y: word SHALL be discarded, orphan_cnt incremented (saturating at 0xFFFF).
REQ-018 Successive X words after one Y SHALL each reuse the same y_hold.
REQ-019 Pushed event SHALL appear on evt_data with evt_valid=1 one cycle after the push edge when the FIFO was empty (latency 2 cycles from rx_valid).
REQ-020 Pop SHALL occur on any edge with evt_valid=1 and evt_ready=1; evt_data and evt_valid SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-021 Push when full with no pop in the same cycle: event SHALL be dropped, overflow_cnt incremented (saturating), FIFO contents unchanged.
REQ-022 Push when full with a pop in the same cycle: push SHALL succeed; fifo_level stays DEPTH.
REQ-023 Simultaneous push and pop at any level SHALL leave fifo_level unchanged; pointers wrap modulo DEPTH.
REQ-024 FIFO SHALL preserve event order.
REQ-025 clr=1 SHALL, at the next edge, empty the FIFO, enter NO_Y, and ignore any rx_valid that cycle; counters are not cleared.
REQ-026 rx_valid=0 SHALL leave y_hold and FSM state unchanged.

Reset
REQ-027 On rst_n=0, asynchronously: FSM=NO_Y, y_hold=0, FIFO empty, evt_valid=0, evt_data=0, fifo_level=0, orphan_cnt=0, overflow_cnt=0.
REQ-028 Reset mid-operation SHALL discard all buffered events; the first post-reset X word is an orphan unless preceded by a Y word.

Configuration
REQ-029 Macro DVS_EVT_STATS_EN SHALL control the statistics counters.
REQ-030 With DVS_EVT_STATS_EN defined, orphan_cnt and overflow_cnt SHALL behave per REQ-017/021.
REQ-031 Without DVS_EVT_STATS_EN, orphan_cnt and overflow_cnt SHALL be constant 0 with no counter registers; drop behaviour is unchanged.

Verification
REQ-032 Y=0x05A, then X=0x0C7 with evt_ready=1 -> evt_data={0x05A,0x063,1} with evt_valid high 2 cycles after the X strobe.
REQ-033 After reset, X=0x010 with no Y -> no event, orphan_cnt=1; then Y=0x001, X=0x010 -> event {0x001,0x008,0}.
REQ-034 DEPTH=8, evt_ready=0, Y then 10 X words -> fifo_level=8, overflow_cnt=2, first 8 events drain in order once evt_ready=1.
REQ-035 FIFO full, X strobe with evt_ready=1 same cycle -> fifo_level stays 8, overflow_cnt unchanged, new event is last drained.
REQ-036 3 events buffered, clr pulse concurrent with X strobe -> fifo_level=0, evt_valid=0, next X without Y counts as orphan.
REQ-037 rst_n asserted asynchronously with 5 events buffered -> all outputs at REQ-027 values before the next clk edge.
